// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the single-port data memory.
package data_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int unsigned READ_LAT_BASE = 1;
    localparam int unsigned MAX_BEW       = 128;
    localparam int unsigned MAX_DW        = 8 * MAX_BEW;

    // Address width for a given depth; never below one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Expands byte enables into a bit mask; callers truncate to their data width.
    function automatic logic [MAX_DW-1:0] be_mask(input logic [MAX_BEW-1:0] be);
        logic [MAX_DW-1:0] m;
        m = '0;
        for (int i = 0; i < int'(MAX_BEW); i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/data_mem_sp_param_if.sv
// Request/response bus between the load/store stage and the data memory.
interface data_mem_sp_param_if
    import data_mem_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned AW  = addr_width(DEPTH);
    localparam int unsigned BEW = DW / 8;

    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [AW-1:0]  req_addr;
    logic [BEW-1:0] req_be;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_clear_seq.sv
// Zero-clear sequencer: walks every word after reset or clr_start, then idles.
module data_mem_clear_seq
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_start_i,
    output logic          clr_sel_o,
    output logic [AW-1:0] clr_ptr_o,
    output logic          ready_o,
    output logic          done_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q,   ptr_d;
    logic          sel_q,   sel_d;
    logic          ready_q, ready_d;
    logic          done_q,  done_d;

    // State register; reset always restarts the clear from word 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            sel_q   <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Next state; status flags are computed from the next state so they stay registered.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (clr_start_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
        sel_d   = (state_d == ST_CLEAR);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_IDLE);
    end

    assign clr_sel_o = sel_q;
    assign clr_ptr_o = ptr_q;
    assign ready_o   = ready_q;
    assign done_o    = done_q;

endmodule

// File: rtl/data_mem_sp_param.sv
// Parametrised single-port data memory with byte enables and hardware zero-clear.
// Optional DATA_MEM_OUTREG_EN adds a second response register (read latency 2).
module data_mem_sp_param
    import data_mem_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_sp_param_if.slave  bus,
    input  logic                clr_start,
    output logic                init_done
);

    localparam int unsigned AW = addr_width(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    logic          clr_sel;
    logic [AW-1:0] clr_ptr;
    logic          ready;

    logic          acc_c, rd_c, wr_c, in_range_c;
    logic          wen_c;
    logic [AW-1:0] waddr_c;
    logic [DW-1:0] wmask_c, wdata_c;

    logic          valid1_q;
    logic [DW-1:0] rdata1_q;
    logic          err1_q;

    data_mem_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .clr_start_i (clr_start),
        .clr_sel_o   (clr_sel),
        .clr_ptr_o   (clr_ptr),
        .ready_o     (ready),
        .done_o      (init_done)
    );

    assign acc_c      = bus.req_valid && ready;
    assign rd_c       = acc_c && !bus.req_we;
    assign wr_c       = acc_c &&  bus.req_we;
    assign in_range_c = (32'(bus.req_addr) < DEPTH);

    // Write port mux: the clear sequencer owns the port while clearing.
    always_comb begin
        wen_c   = 1'b0;
        waddr_c = bus.req_addr;
        wmask_c = DW'(be_mask(MAX_BEW'(bus.req_be)));
        wdata_c = bus.req_wdata;
        if (clr_sel) begin
            wen_c   = 1'b1;
            waddr_c = clr_ptr;
            wmask_c = '1;
            wdata_c = '0;
        end else if (wr_c && in_range_c) begin
            wen_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wen_c) begin
            mem_q[waddr_c] <= (mem_q[waddr_c] & ~wmask_c) | (wdata_c & wmask_c);
        end
    end

    // First response stage; out-of-range reads return zero with the error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid1_q <= 1'b0;
            rdata1_q <= '0;
            err1_q   <= 1'b0;
        end else begin
            valid1_q <= rd_c;
            if (rd_c) begin
                rdata1_q <= in_range_c ? mem_q[bus.req_addr] : '0;
                err1_q   <= !in_range_c;
            end
        end
    end

`ifdef DATA_MEM_OUTREG_EN
    logic          valid2_q;
    logic [DW-1:0] rdata2_q;
    logic          err2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid2_q <= 1'b0;
            rdata2_q <= '0;
            err2_q   <= 1'b0;
        end else begin
            valid2_q <= valid1_q;
            if (valid1_q) begin
                rdata2_q <= rdata1_q;
                err2_q   <= err1_q;
            end
        end
    end

    assign bus.rsp_valid = valid2_q;
    assign bus.rsp_rdata = rdata2_q;
    assign bus.rsp_err   = err2_q;
`else
    assign bus.rsp_valid = valid1_q;
    assign bus.rsp_rdata = rdata1_q;
    assign bus.rsp_err   = err1_q;
`endif

    assign bus.req_ready = ready;

endmodule
